// File: rtl/mem_pkg.sv
// Shared widths, base-select encodings and FSM states for the memory access unit.
package mem_pkg;
  localparam int AW = 12;
  localparam int DW = 12;

  localparam logic [1:0] BASE_ABS = 2'd0;
  localparam logic [1:0] BASE_P1  = 2'd1;
  localparam logic [1:0] BASE_P2  = 2'd2;
  localparam logic [1:0] BASE_P3  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// Single-word request/acknowledge data-memory port.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_addr_gen.sv
// Effective address and pending pointer value from base pointer, offset and mode flags.
module mem_addr_gen
  import mem_pkg::*;
(
  input  logic [AW-1:0] ptr,
  input  logic [1:0]    base,
  input  logic [3:0]    offset,
  input  logic          post_inc,
  input  logic          pre_dec,
  output logic [AW-1:0] addr,
  output logic          upd_en,
  output logic [AW-1:0] upd_val,
  output logic          mode_err,
  output logic          mode_conflict
);
  logic [AW-1:0] offset_ext;

  assign offset_ext = {{(AW-4){1'b0}}, offset};

  always_comb begin
    addr          = ptr + offset_ext;
    upd_en        = 1'b0;
    upd_val       = ptr;
    mode_err      = 1'b0;
    mode_conflict = post_inc & pre_dec;
    if (base == BASE_ABS) begin
      // Absolute accesses have no pointer to update; inc/dec is flagged but the access proceeds.
      addr     = offset_ext;
      mode_err = post_inc | pre_dec;
    end else if (post_inc && !pre_dec) begin
      addr    = ptr;
      upd_en  = 1'b1;
      upd_val = ptr + AW'(1);
    end else if (pre_dec && !post_inc) begin
      addr    = ptr - AW'(1);
      upd_en  = 1'b1;
      upd_val = ptr - AW'(1);
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: owns pointers P1-P3, issues one memory transaction per start.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          req_read,
  input  logic          req_write,
  input  logic [1:0]    req_base,
  input  logic [3:0]    req_offset,
  input  logic          req_post_inc,
  input  logic          req_pre_dec,
  input  logic [DW-1:0] req_wdata,
  input  logic          ptr_wr_en,
  input  logic [1:0]    ptr_wr_sel,
  input  logic [AW-1:0] ptr_wr_data,
  output logic [AW-1:0] ptr1,
  output logic [AW-1:0] ptr2,
  output logic [AW-1:0] ptr3,
  mem_access_unit_if.master mem,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err
);
  state_t        state_reg, state_next;
  logic          req_reg, req_next, we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next, rdata_reg, rdata_next;
  logic          done_reg, done_next, err_reg, err_next;
  logic          pend_en_reg, pend_en_next;
  logic [1:0]    pend_sel_reg, pend_sel_next;
  logic [AW-1:0] pend_val_reg, pend_val_next;
  logic          commit;
  logic [AW-1:0] ptr_val [4];
  logic [AW-1:0] gen_addr, gen_upd_val;
  logic          gen_upd_en, gen_mode_err, gen_conflict;

  assign ptr_val[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_ptr
      logic [AW-1:0] val_reg, val_next;

      // Auto-update commit is applied last so it overrides a same-cycle register-file write.
      always_comb begin
        val_next = val_reg;
        if (ptr_wr_en && ptr_wr_sel == 2'(gi))
          val_next = ptr_wr_data;
        if (commit && pend_sel_reg == 2'(gi))
          val_next = pend_val_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val_reg <= '0;
        else        val_reg <= val_next;
      end

      assign ptr_val[gi] = val_reg;
    end
  endgenerate

  assign ptr1 = ptr_val[1];
  assign ptr2 = ptr_val[2];
  assign ptr3 = ptr_val[3];

  mem_addr_gen u_addr_gen (
    .ptr           (ptr_val[req_base]),
    .base          (req_base),
    .offset        (req_offset),
    .post_inc      (req_post_inc),
    .pre_dec       (req_pre_dec),
    .addr          (gen_addr),
    .upd_en        (gen_upd_en),
    .upd_val       (gen_upd_val),
    .mode_err      (gen_mode_err),
    .mode_conflict (gen_conflict)
  );

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    pend_en_next  = pend_en_reg;
    pend_sel_next = pend_sel_reg;
    pend_val_next = pend_val_reg;
    commit        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && (req_read || req_write)) begin
          if ((req_read && req_write) || gen_conflict) begin
            err_next = 1'b1;
          end else begin
            err_next      = gen_mode_err;
            req_next      = 1'b1;
            we_next       = req_write;
            addr_next     = gen_addr;
            wdata_next    = req_wdata;
            pend_en_next  = gen_upd_en;
            pend_sel_next = req_base;
            pend_val_next = gen_upd_val;
            state_next    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          req_next     = 1'b0;
          done_next    = 1'b1;
          commit       = pend_en_reg;
          pend_en_next = 1'b0;
          if (!we_reg)
            rdata_next = mem.mem_rdata;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      pend_en_reg  <= 1'b0;
      pend_sel_reg <= '0;
      pend_val_reg <= '0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      pend_en_reg  <= pend_en_next;
      pend_sel_reg <= pend_sel_next;
      pend_val_reg <= pend_val_next;
    end
  end

  assign mem.mem_req   = req_reg;
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign busy          = (state_reg == ST_REQ);
  assign done          = done_reg;
  assign rdata         = rdata_reg;
  assign err           = err_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: driver queues expected requests, a memory responder and a done monitor check them.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 0, req_read = 0, req_write = 0;
  logic [1:0]    req_base = 0;
  logic [3:0]    req_offset = 0;
  logic          req_post_inc = 0, req_pre_dec = 0;
  logic [DW-1:0] req_wdata = 0;
  logic          drv_wr_en = 0;
  logic [1:0]    drv_wr_sel = 0;
  logic [AW-1:0] drv_wr_data = 0;
  logic          coll_wr = 0;
  logic          ptr_wr_en;
  logic [1:0]    ptr_wr_sel;
  logic [AW-1:0] ptr_wr_data;
  logic [AW-1:0] ptr1, ptr2, ptr3;
  logic          busy, done, err;
  logic [DW-1:0] rdata;

  assign ptr_wr_en   = drv_wr_en | coll_wr;
  assign ptr_wr_sel  = coll_wr ? 2'd1 : drv_wr_sel;
  assign ptr_wr_data = coll_wr ? 12'h555 : drv_wr_data;

  mem_access_unit_if mem_bus ();

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_post_inc (req_post_inc),
    .req_pre_dec  (req_pre_dec),
    .req_wdata    (req_wdata),
    .ptr_wr_en    (ptr_wr_en),
    .ptr_wr_sel   (ptr_wr_sel),
    .ptr_wr_data  (ptr_wr_data),
    .ptr1         (ptr1),
    .ptr2         (ptr2),
    .ptr3         (ptr3),
    .mem          (mem_bus),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .err          (err)
  );

  typedef struct {
    int addr; int we; int wdata; int p1; int p2; int p3; int rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t done_q[$];
  int   model_p[4];
  int   passed = 0, total = 0;
  int   fdelay = -1, frdata = -1;
  bit   hold_ack = 0, coll_arm = 0;
  txn_t resp_cur;
  int   resp_wait;
  bit   resp_active = 0;
  int   last_rdata = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int get_ptr(int n);
    case (n)
      1: return int'(ptr1);
      2: return int'(ptr2);
      3: return int'(ptr3);
      default: return 0;
    endcase
  endfunction

  // Memory responder: pops the expected request, checks it is held, then acks.
  initial begin
    mem_bus.mem_ack   = 0;
    mem_bus.mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_active = 0; mem_bus.mem_ack = 0; coll_wr = 0;
      end else if (mem_bus.mem_ack) begin
        mem_bus.mem_ack = 0; coll_wr = 0; resp_active = 0;
        check("req_drop", mem_bus.mem_req, 0);
      end else if (mem_bus.mem_req) begin
        if (!resp_active) begin
          check("req_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) resp_cur = exp_q.pop_front();
          else resp_cur = '{int'(mem_bus.mem_addr), int'(mem_bus.mem_we), int'(mem_bus.mem_wdata),
                            model_p[1], model_p[2], model_p[3], 0};
          check("req_addr", mem_bus.mem_addr, resp_cur.addr);
          check("req_we", mem_bus.mem_we, resp_cur.we);
          if (resp_cur.we != 0) check("req_wdata", mem_bus.mem_wdata, resp_cur.wdata);
          check("req_busy", busy, 1);
          resp_active = 1;
          resp_wait = (fdelay >= 0) ? fdelay : int'($urandom_range(0, 3));
        end else begin
          check("hold_addr", mem_bus.mem_addr, resp_cur.addr);
          check("hold_we", mem_bus.mem_we, resp_cur.we);
          if (resp_cur.we != 0) check("hold_wdata", mem_bus.mem_wdata, resp_cur.wdata);
        end
        if (!hold_ack) begin
          if (resp_wait == 0) begin
            int rd;
            rd = (frdata >= 0) ? frdata : int'($urandom_range(0, 4095));
            mem_bus.mem_ack   = 1;
            mem_bus.mem_rdata = DW'(rd);
            resp_cur.rdata = (resp_cur.we != 0) ? -1 : rd;
            if (coll_arm) coll_wr = 1;
            done_q.push_back(resp_cur);
          end else begin
            resp_wait--;
          end
        end
      end
    end
  end

  // Done monitor: checks load data, rdata hold on stores and committed pointers.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rdata = 0;
      end else if (done) begin
        check("done_expected", int'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          txn_t t;
          int exp_rd;
          t = done_q.pop_front();
          exp_rd = (t.rdata >= 0) ? t.rdata : last_rdata;
          check("done_rdata", rdata, exp_rd);
          last_rdata = exp_rd;
          check("done_ptr1", ptr1, t.p1);
          check("done_ptr2", ptr2, t.p2);
          check("done_ptr3", ptr3, t.p3);
          check("done_busy", busy, 0);
          $display("txn addr=0x%03h we=%0d rdata=0x%03h ptrs=%03h/%03h/%03h",
                   t.addr, t.we, rdata, ptr1, ptr2, ptr3);
        end
      end
    end
  end

  task automatic ptr_write(int sel, int data);
    drv_wr_en = 1; drv_wr_sel = 2'(sel); drv_wr_data = AW'(data);
    @(negedge clk);
    drv_wr_en = 0;
    if (sel != 0) begin
      model_p[sel] = data;
      check("ptr_write", get_ptr(sel), model_p[sel]);
    end
  endtask

  // Reference model: address/pointer rules in plain modulo-4096 arithmetic.
  function automatic txn_t model_txn(bit rd, bit wr, int base, int off, bit pi, bit pd, int wd);
    txn_t t;
    int p;
    p = (base == 0) ? 0 : model_p[base];
    if (base == 0)  t.addr = off;
    else if (pi)    begin t.addr = p; model_p[base] = (p + 1) % 4096; end
    else if (pd)    begin t.addr = (p + 4095) % 4096; model_p[base] = t.addr; end
    else            t.addr = (p + off) % 4096;
    t.we = wr ? 1 : 0;
    t.wdata = wd;
    t.p1 = model_p[1]; t.p2 = model_p[2]; t.p3 = model_p[3];
    t.rdata = 0;
    return t;
  endfunction

  task automatic drive_req(bit rd, bit wr, int base, int off, bit pi, bit pd, int wd);
    start = 1; req_read = rd; req_write = wr; req_base = 2'(base);
    req_offset = 4'(off); req_post_inc = pi; req_pre_dec = pd; req_wdata = DW'(wd);
  endtask

  task automatic do_txn(bit rd, bit wr, int base, int off, bit pi, bit pd, int wd, string tag);
    bit legal, eflag;
    int n;
    legal = (rd ^ wr) && !(pi && pd);
    eflag = (rd && wr) || ((rd || wr) && ((pi && pd) || (base == 0 && (pi || pd))));
    drive_req(rd, wr, base, off, pi, pd, wd);
    if (legal) exp_q.push_back(model_txn(rd, wr, base, off, pi, pd, wd));
    @(negedge clk);
    start = 0;
    check({tag, "_err"}, err, eflag);
    if (!legal) begin
      check({tag, "_no_req"}, mem_bus.mem_req, 0);
      check({tag, "_no_busy"}, busy, 0);
    end else begin
      n = 0;
      while (done !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_done_seen"}, done, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) model_p[i] = 0;
    #1;
    check("rst_req", mem_bus.mem_req, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_bus.mem_addr, 0);
    check("rst_ptrs", int'(ptr1) + int'(ptr2) + int'(ptr3), 0);
    rst_n = 1;
    @(negedge clk);

    fdelay = 1; frdata = 'h2A3;
    do_txn(1, 0, 0, 5, 0, 0, 0, "abs_load");
    frdata = -1;
    ptr_write(2, 'h100);
    fdelay = 3;
    do_txn(0, 1, 2, 'hF, 0, 0, 'h7E1, "idx_store");
    fdelay = -1;
    ptr_write(1, 'hFFF);
    do_txn(1, 0, 1, 0, 1, 0, 0, "post_wrap");
    ptr_write(3, 0);
    do_txn(0, 1, 3, 0, 0, 1, 'h123, "pre_wrap");

    // Collision on the ack cycle, with start held high throughout the transaction.
    ptr_write(1, 'h010);
    coll_arm = 1; fdelay = 2;
    drive_req(1, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(model_txn(1, 0, 1, 0, 1, 0, 0));
    begin
      int n;
      n = 0;
      @(negedge clk);
      drive_req(1, 0, 2, 3, 0, 0, 0);
      while (done !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("coll_done_seen", done, 1);
      start = 0;
      @(negedge clk);
      check("busy_start_ignored", mem_bus.mem_req, 0);
      check("coll_ptr1", ptr1, 'h011);
    end
    coll_arm = 0; fdelay = -1;

    do_txn(0, 0, 1, 2, 0, 0, 0, "no_op");
    do_txn(1, 1, 1, 2, 0, 0, 0, "rw_both");
    @(negedge clk);
    check("err_pulse_len", err, 0);
    do_txn(1, 0, 2, 1, 1, 1, 0, "inc_dec");
    do_txn(1, 0, 0, 7, 1, 0, 0, "abs_inc");

    // Asynchronous reset while a P2 pre-decrement store is outstanding.
    ptr_write(2, 'h040);
    hold_ack = 1;
    drive_req(0, 1, 2, 0, 0, 1, 'h321);
    exp_q.push_back(model_txn(0, 1, 2, 0, 0, 1, 'h321));
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check("arst_req", mem_bus.mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ptr2", ptr2, 0);
    for (int i = 0; i < 4; i++) model_p[i] = 0;
    @(negedge clk);
    @(negedge clk);
    hold_ack = 0;
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_ptr2", ptr2, 0);
    end

    for (int i = 0; i < 40; i++) begin
      bit rd, wr, pi, pd;
      int base, mode;
      if ($urandom_range(0, 2) == 0)
        ptr_write(int'($urandom_range(1, 3)), int'($urandom_range(0, 4095)));
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      base = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 2));
      pi = (mode == 1);
      pd = (mode == 2);
      if ($urandom_range(0, 9) == 0) begin rd = 1; wr = 1; end
      if ($urandom_range(0, 9) == 0) begin pi = 1; pd = 1; end
      do_txn(rd, wr, base, int'($urandom_range(0, 15)), pi, pd,
             int'($urandom_range(0, 4095)), "rand");
    end

    repeat (4) @(negedge clk);
    check("queues_drained", exp_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
